// File: rtl/l2_fwd_stall_ctrl_pkg.sv
// Shared constants and types for the L2 forward-stall controller slice.
// Holds the cache geometry, the FSM state type and the held-forward record.
package l2_fwd_stall_ctrl_pkg;

    localparam int N_REQS         = 4;
    localparam int REQS_BITS      = 2;
    localparam int SET_BITS       = 8;
    localparam int LINE_ADDR_BITS = 26;
    localparam int MIX_MSG_BITS   = 3;
    localparam int CACHE_ID_BITS  = 4;
    localparam int STATE_BITS     = 4;
    localparam int CNT_BITS       = 16;

    typedef logic [REQS_BITS-1:0]      req_idx_t;
    typedef logic [MIX_MSG_BITS-1:0]   mix_msg_t;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [CACHE_ID_BITS-1:0]  cache_id_t;
    typedef logic [SET_BITS-1:0]       l2_set_t;
    typedef logic [STATE_BITS-1:0]     unstable_state_t;

    localparam unstable_state_t INVALID = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        REPLAY = 2'd2
    } fwd_stall_state_t;

    typedef struct packed {
        mix_msg_t   coh_msg;
        line_addr_t addr;
        cache_id_t  req_id;
    } fwd_held_t;

endpackage

// File: rtl/l2_fwd_stall_ctrl_set_conflict.sv
// Tracks whether the peeked CPU request is stalled on a busy set and pulses
// a release when a request entry in that set drops back to INVALID.
module l2_set_conflict_tracker
    import l2_fwd_stall_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_i,
    input  logic                  clr_i,
    input  logic [SET_BITS-1:0]   set_in_i,
    input  logic                  upd_valid_i,
    input  logic [STATE_BITS-1:0] upd_state_i,
    input  logic [SET_BITS-1:0]   upd_set_i,
    output logic                  set_conflict_o,
    output logic                  release_o
);

    logic    conflict_q, conflict_d;
    l2_set_t conflict_set_q, conflict_set_d;
    logic    release_q, release_d;
    logic    set_freed;

    assign set_freed = conflict_q && upd_valid_i && (upd_state_i == INVALID)
                       && (upd_set_i == conflict_set_q);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        conflict_d     = conflict_q;
        conflict_set_d = conflict_set_q;
        release_d      = 1'b0;
        // A fresh conflict outranks a release landing in the same cycle.
        if (set_i) begin
            conflict_d     = 1'b1;
            conflict_set_d = set_in_i;
        end else if (set_freed) begin
            conflict_d = 1'b0;
            release_d  = 1'b1;
        end else if (clr_i) begin
            conflict_d = 1'b0;
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_q     <= 1'b0;
            conflict_set_q <= '0;
            release_q      <= 1'b0;
        end else begin
            conflict_q     <= conflict_d;
            conflict_set_q <= conflict_set_d;
            release_q      <= release_d;
        end
    end

    assign set_conflict_o = conflict_q;
    assign release_o      = release_q;

endmodule

// File: rtl/l2_fwd_stall_ctrl.sv
// Holds one forward that hit an in-flight request, blocks forward intake while
// held, and replays it to the L2 controller once the blocking entry is updated.
module l2_fwd_stall_ctrl
    import l2_fwd_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_fwd_stall,
    input  logic                      clr_fwd_stall,
    input  logic [REQS_BITS-1:0]      fwd_stall_i_wr_data,
    input  logic [MIX_MSG_BITS-1:0]   fwd_cap_coh_msg,
    input  logic [LINE_ADDR_BITS-1:0] fwd_cap_addr,
    input  logic [CACHE_ID_BITS-1:0]  fwd_cap_req_id,
    input  logic                      set_set_conflict_reqs,
    input  logic                      clr_set_conflict_reqs,
    input  logic [SET_BITS-1:0]       conflict_set_in,
    input  logic                      req_upd_valid,
    input  logic [REQS_BITS-1:0]      req_upd_i,
    input  logic [STATE_BITS-1:0]     req_upd_state,
    input  logic [SET_BITS-1:0]       req_upd_set,
    input  logic                      fwd_replay_ready,
    output logic                      fwd_stall,
    output logic [REQS_BITS-1:0]      fwd_stall_i,
    output logic                      fwd_replay_valid,
    output logic [MIX_MSG_BITS-1:0]   fwd_replay_coh_msg,
    output logic [LINE_ADDR_BITS-1:0] fwd_replay_addr,
    output logic [CACHE_ID_BITS-1:0]  fwd_replay_req_id,
    output logic                      set_conflict,
    output logic                      set_conflict_release,
    output logic [CNT_W-1:0]          stall_cycles
);

    fwd_stall_state_t  state_q, state_d;
    fwd_held_t         held_q, held_d;
    req_idx_t          idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // clr_fwd_stall only matters when set is low, which is the IDLE default anyway.
    logic unused_ok;
    assign unused_ok = clr_fwd_stall;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (set_fwd_stall) begin
                    held_d  = '{coh_msg: fwd_cap_coh_msg, addr: fwd_cap_addr,
                                req_id: fwd_cap_req_id};
                    idx_d   = fwd_stall_i_wr_data;
                    state_d = STALL;
                end
            end
            STALL: begin
                if (req_upd_valid && (req_upd_i == idx_q)) state_d = REPLAY;
            end
            // Updates seen here are ignored: the held entry was already released.
            REPLAY: begin
                if (fwd_replay_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != IDLE) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            held_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_stall          = (state_q != IDLE);
    assign fwd_replay_valid   = (state_q == REPLAY);
    assign fwd_stall_i        = idx_q;
    assign fwd_replay_coh_msg = held_q.coh_msg;
    assign fwd_replay_addr    = held_q.addr;
    assign fwd_replay_req_id  = held_q.req_id;
    assign stall_cycles       = cnt_q;

    l2_set_conflict_tracker u_conflict (
        .clk            (clk),
        .rst            (rst),
        .set_i          (set_set_conflict_reqs),
        .clr_i          (clr_set_conflict_reqs),
        .set_in_i       (conflict_set_in),
        .upd_valid_i    (req_upd_valid),
        .upd_state_i    (req_upd_state),
        .upd_set_i      (req_upd_set),
        .set_conflict_o (set_conflict),
        .release_o      (set_conflict_release)
    );

    // A second forward must not be presented while one is already held.
    a_no_set_in_stall: assert property (@(posedge clk) disable iff (!rst)
        !((state_q == STALL) && set_fwd_stall));

endmodule

// File: tb/tb_l2_fwd_stall_ctrl.sv
// Self-checking bench for l2_fwd_stall_ctrl: directed sequences, a conflict
// vector table and randomized traffic against a behavioural model.
module tb_l2_fwd_stall_ctrl;
    import l2_fwd_stall_ctrl_pkg::*;

    localparam int TB_CNT_W = 6;
    localparam int CMAX     = (1 << TB_CNT_W) - 1;
    localparam logic [2:0] FWD_GETM = 3'd2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      set_fwd_stall, clr_fwd_stall;
    logic [REQS_BITS-1:0]      fwd_stall_i_wr_data;
    logic [MIX_MSG_BITS-1:0]   fwd_cap_coh_msg;
    logic [LINE_ADDR_BITS-1:0] fwd_cap_addr;
    logic [CACHE_ID_BITS-1:0]  fwd_cap_req_id;
    logic                      set_set_conflict_reqs, clr_set_conflict_reqs;
    logic [SET_BITS-1:0]       conflict_set_in;
    logic                      req_upd_valid;
    logic [REQS_BITS-1:0]      req_upd_i;
    logic [STATE_BITS-1:0]     req_upd_state;
    logic [SET_BITS-1:0]       req_upd_set;
    logic                      fwd_replay_ready;
    logic                      fwd_stall;
    logic [REQS_BITS-1:0]      fwd_stall_i;
    logic                      fwd_replay_valid;
    logic [MIX_MSG_BITS-1:0]   fwd_replay_coh_msg;
    logic [LINE_ADDR_BITS-1:0] fwd_replay_addr;
    logic [CACHE_ID_BITS-1:0]  fwd_replay_req_id;
    logic                      set_conflict, set_conflict_release;
    logic [TB_CNT_W-1:0]       stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_fwd_stall_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .set_fwd_stall(set_fwd_stall), .clr_fwd_stall(clr_fwd_stall),
        .fwd_stall_i_wr_data(fwd_stall_i_wr_data),
        .fwd_cap_coh_msg(fwd_cap_coh_msg), .fwd_cap_addr(fwd_cap_addr),
        .fwd_cap_req_id(fwd_cap_req_id),
        .set_set_conflict_reqs(set_set_conflict_reqs),
        .clr_set_conflict_reqs(clr_set_conflict_reqs),
        .conflict_set_in(conflict_set_in),
        .req_upd_valid(req_upd_valid), .req_upd_i(req_upd_i),
        .req_upd_state(req_upd_state), .req_upd_set(req_upd_set),
        .fwd_replay_ready(fwd_replay_ready),
        .fwd_stall(fwd_stall), .fwd_stall_i(fwd_stall_i),
        .fwd_replay_valid(fwd_replay_valid),
        .fwd_replay_coh_msg(fwd_replay_coh_msg),
        .fwd_replay_addr(fwd_replay_addr), .fwd_replay_req_id(fwd_replay_req_id),
        .set_conflict(set_conflict), .set_conflict_release(set_conflict_release),
        .stall_cycles(stall_cycles)
    );

    // Behavioural model: "holding" a forward, and whether it is being "offered".
    bit                        m_holding, m_offered;
    logic [REQS_BITS-1:0]      m_idx;
    logic [MIX_MSG_BITS-1:0]   m_msg;
    logic [LINE_ADDR_BITS-1:0] m_addr;
    logic [CACHE_ID_BITS-1:0]  m_id;
    int                        m_cnt;
    bit                        m_conf, m_rel;
    logic [SET_BITS-1:0]       m_cset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_holding = m_holding;
        if (!rst) begin
            m_holding = 0; m_offered = 0; m_idx = '0; m_msg = '0; m_addr = '0; m_id = '0;
            m_cnt = 0; m_conf = 0; m_rel = 0; m_cset = '0;
        end else begin
            if (!m_holding) begin
                if (set_fwd_stall) begin
                    m_holding = 1;
                    m_idx = fwd_stall_i_wr_data; m_msg = fwd_cap_coh_msg;
                    m_addr = fwd_cap_addr; m_id = fwd_cap_req_id;
                end
            end else if (!m_offered) begin
                if (req_upd_valid && req_upd_i == m_idx) m_offered = 1;
            end else if (fwd_replay_ready) begin
                m_holding = 0; m_offered = 0;
            end
            if (was_holding) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            m_rel = 0;
            if (set_set_conflict_reqs) begin
                m_conf = 1; m_cset = conflict_set_in;
            end else if (m_conf && req_upd_valid && req_upd_state == 0 && req_upd_set == m_cset) begin
                m_conf = 0; m_rel = 1;
            end else if (clr_set_conflict_reqs) begin
                m_conf = 0;
            end
        end
    endtask

    task automatic check_all();
        check("fwd_stall",   32'(fwd_stall),            32'(m_holding));
        check("fwd_stall_i", 32'(fwd_stall_i),          32'(m_idx));
        check("replay_vld",  32'(fwd_replay_valid),     32'(m_offered));
        check("replay_msg",  32'(fwd_replay_coh_msg),   32'(m_msg));
        check("replay_addr", 32'(fwd_replay_addr),      32'(m_addr));
        check("replay_id",   32'(fwd_replay_req_id),    32'(m_id));
        check("set_confl",   32'(set_conflict),         32'(m_conf));
        check("confl_rel",   32'(set_conflict_release), 32'(m_rel));
        check("stall_cyc",   32'(stall_cycles),         32'(m_cnt));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        rst = 1'b1;
        set_fwd_stall = 1'b0; clr_fwd_stall = 1'b0; fwd_stall_i_wr_data = '0;
        fwd_cap_coh_msg = '0; fwd_cap_addr = '0; fwd_cap_req_id = '0;
        set_set_conflict_reqs = 1'b0; clr_set_conflict_reqs = 1'b0; conflict_set_in = '0;
        req_upd_valid = 1'b0; req_upd_i = '0; req_upd_state = '0; req_upd_set = '0;
        fwd_replay_ready = 1'b0;
    endtask

    typedef struct {
        bit                  set;
        bit                  clr;
        logic [SET_BITS-1:0] cset;
        bit                  uv;
        logic [3:0]          ust;
        logic [SET_BITS-1:0] uset;
        bit                  e_conf;
        bit                  e_rel;
    } cvec_t;

    cvec_t tbl[14];

    initial begin
        logic [31:0] r;

        tbl[0]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 8'h3D, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h5, 8'h3C, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 8'h3C, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h10, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h20, 1'b1, 4'h0, 8'h10, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 8'h10, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 8'h20, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h44, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 4'h0, 8'h44, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};

        quiet();
        rst = 1'b0;
        step(); step();
        check("rst_stall",  32'(fwd_stall),        32'd0);
        check("rst_replay", 32'(fwd_replay_valid), 32'd0);
        check("rst_cnt",    32'(stall_cycles),     32'd0);
        check("rst_confl",  32'(set_conflict),     32'd0);
        rst = 1'b1;

        // Capture, replay after update, payload held under backpressure.
        set_fwd_stall = 1'b1; fwd_stall_i_wr_data = 2'd2; fwd_cap_coh_msg = FWD_GETM;
        fwd_cap_addr = 26'h0ABCDE; fwd_cap_req_id = 4'd5;
        step();
        quiet();
        check("s1_stall",   32'(fwd_stall),        32'd1);
        check("s1_idx",     32'(fwd_stall_i),      32'd2);
        check("s1_noreply", 32'(fwd_replay_valid), 32'd0);
        req_upd_valid = 1'b1; req_upd_i = 2'd2; req_upd_state = 4'd0;
        step();
        quiet();
        check("s1_replay",  32'(fwd_replay_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("s1_hold_v",    32'(fwd_replay_valid),   32'd1);
            check("s1_hold_addr", 32'(fwd_replay_addr),    32'h0ABCDE);
            check("s1_hold_id",   32'(fwd_replay_req_id),  32'd5);
            check("s1_hold_msg",  32'(fwd_replay_coh_msg), 32'(FWD_GETM));
        end
        fwd_replay_ready = 1'b1;
        step();
        quiet();
        check("s1_idle",    32'(fwd_stall),        32'd0);
        check("s1_cnt",     32'(stall_cycles),     32'd5);
        step();
        check("s1_cnt_hold", 32'(stall_cycles),    32'd5);

        // Non-matching update is ignored; matching one with a non-INVALID state releases.
        set_fwd_stall = 1'b1; fwd_stall_i_wr_data = 2'd2;
        step();
        quiet();
        req_upd_valid = 1'b1; req_upd_i = 2'd1;
        step();
        check("s2_other_idx", 32'(fwd_replay_valid), 32'd0);
        req_upd_i = 2'd2; req_upd_state = 4'h9;
        step();
        quiet();
        check("s2_replay",  32'(fwd_replay_valid), 32'd1);
        fwd_replay_ready = 1'b1;
        step();
        quiet();
        check("s2_cnt",     32'(stall_cycles),     32'd8);

        // Update coinciding with replay accept does not re-arm anything.
        set_fwd_stall = 1'b1; fwd_stall_i_wr_data = 2'd1;
        step();
        quiet();
        req_upd_valid = 1'b1; req_upd_i = 2'd1;
        step();
        fwd_replay_ready = 1'b1;
        step();
        quiet();
        check("s3_accept", 32'(fwd_stall), 32'd0);
        step();
        check("s3_idle",   32'(fwd_replay_valid), 32'd0);

        // Set-conflict vectors.
        foreach (tbl[i]) begin
            set_set_conflict_reqs = tbl[i].set; clr_set_conflict_reqs = tbl[i].clr;
            conflict_set_in = tbl[i].cset; req_upd_valid = tbl[i].uv;
            req_upd_state = tbl[i].ust; req_upd_set = tbl[i].uset;
            step();
            check($sformatf("tbl%0d_conf", i), 32'(set_conflict),         32'(tbl[i].e_conf));
            check($sformatf("tbl%0d_rel", i),  32'(set_conflict_release), 32'(tbl[i].e_rel));
        end
        quiet();

        // Reset mid-replay, then simultaneous set/clr in IDLE.
        set_fwd_stall = 1'b1; fwd_stall_i_wr_data = 2'd3;
        step();
        quiet();
        req_upd_valid = 1'b1; req_upd_i = 2'd3;
        step();
        quiet();
        check("s4_replay", 32'(fwd_replay_valid), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("s4_rst_v",     32'(fwd_replay_valid), 32'd0);
        check("s4_rst_stall", 32'(fwd_stall),        32'd0);
        check("s4_rst_cnt",   32'(stall_cycles),     32'd0);
        set_fwd_stall = 1'b1; clr_fwd_stall = 1'b1; fwd_stall_i_wr_data = 2'd3;
        step();
        quiet();
        check("s4_setwins", 32'(fwd_stall),   32'd1);
        check("s4_idx",     32'(fwd_stall_i), 32'd3);

        // Saturation of the stall counter.
        repeat (70) step();
        check("sat_max", 32'(stall_cycles), 32'(CMAX));
        req_upd_valid = 1'b1; req_upd_i = 2'd3;
        step();
        quiet();
        fwd_replay_ready = 1'b1;
        step();
        quiet();
        check("sat_hold", 32'(stall_cycles), 32'(CMAX));

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            rst = ($urandom_range(0, 199) != 0);
            set_fwd_stall = (m_holding && !m_offered) ? 1'b0 : ($urandom_range(0, 3) == 0);
            clr_fwd_stall = r[0];
            fwd_stall_i_wr_data = r[2:1];
            fwd_cap_coh_msg = r[5:3];
            fwd_cap_req_id = r[9:6];
            r = $urandom;
            fwd_cap_addr = r[25:0];
            r = $urandom;
            set_set_conflict_reqs = ($urandom_range(0, 5) == 0);
            clr_set_conflict_reqs = ($urandom_range(0, 7) == 0);
            conflict_set_in = 8'h3C | SET_BITS'(r[1:0]);
            req_upd_valid = ($urandom_range(0, 2) == 0);
            req_upd_i = r[3:2];
            req_upd_state = {2'b00, r[5:4]};
            req_upd_set = 8'h3C | SET_BITS'(r[7:6]);
            fwd_replay_ready = r[8];
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
